// File: rtl/execute_stage_mc.sv
// -----------------------------------------------------------------------------
// execute_stage_mc
//
// Execute stage of the pipelined MIPS CPU. It contains:
//   - operand forwarding muxes (register file / EX/MEM aluout / wb_data)
//   - the ALU and its decode from ALUOp and funct
//   - a multi-cycle multiply that holds the front end with ex_stall
//   - the registered EX/MEM pipeline register with a valid bit
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   in_valid           ID/EX holds a real instruction
//   RegDst .. Branch   decoded single-bit controls
//   ALUOp              ALU operation class
//   npc                PC+4
//   rdata1, rdata2     register-file operands
//   s_extend           sign-extended immediate, [5:0] doubles as funct
//   rt, rd             destination candidates
//   fwd_a, fwd_b       operand source (00/11 regfile, 01 aluout, 10 wb_data)
//   wb_data            write-back-stage result
//   flush              kill the instruction in EX (synchronous)
//   ex_stall           hold PC, IF/ID and ID/EX this cycle (combinational)
//   out_valid          EX/MEM holds a real instruction
//   ctlwb_out          {RegWrite, MemtoReg}
//   ctlm_out           {Branch, MemRead, MemWrite}
//   branch_target      npc + (s_extend << 2)
//   aluout, aluzero    result and result == 0
//   store_data         forwarded B operand, before the ALUSrc mux
//   dest_reg           rd if RegDst, else rt
// -----------------------------------------------------------------------------
module execute_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_stall,
  output logic              out_valid,
  output logic [1:0]        ctlwb_out,
  output logic [2:0]        ctlm_out,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] aluout,
  output logic              aluzero,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] dest_reg
);

  // Counter only has to hold MUL_CYCLES-2.
  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 2);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  } alu_fn_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mul_a;
  logic [DATA_W-1:0]  mul_b;

  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b_raw;
  logic [DATA_W-1:0]  op_b;
  logic [5:0]         funct;
  alu_fn_t            alu_fn;
  logic [DATA_W-1:0]  alu_result;
  logic [DATA_W-1:0]  product;
  logic [DATA_W-1:0]  result_d;
  logic               is_mult;
  logic               complete_mul;
  logic               load_ex;

  assign funct = s_extend[5:0];

  // ---------------------------------------------------------------------------
  // Forwarding. Selection 01 takes the registered EX/MEM result.
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (fwd_a)
      2'b01:   op_a = aluout;
      2'b10:   op_a = wb_data;
      default: op_a = rdata1;
    endcase
    unique case (fwd_b)
      2'b01:   op_b_raw = aluout;
      2'b10:   op_b_raw = wb_data;
      default: op_b_raw = rdata2;
    endcase
  end

  assign op_b = ALUSrc ? s_extend : op_b_raw;

  // ---------------------------------------------------------------------------
  // ALU decode and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves alu_fn
    // unassigned, which would otherwise infer a latch.
    alu_fn = ALU_ADD;
    case (ALUOp)
      2'b01: alu_fn = ALU_SUB;
      2'b11: alu_fn = ALU_OR;
      2'b10: begin
        case (funct)
          6'h22:   alu_fn = ALU_SUB;
          6'h24:   alu_fn = ALU_AND;
          6'h25:   alu_fn = ALU_OR;
          6'h2A:   alu_fn = ALU_SLT;
          6'h18:   alu_fn = ALU_MUL;
          default: alu_fn = ALU_ADD;
        endcase
      end
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_result = op_a + op_b;
    case (alu_fn)
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_SLT: alu_result = DATA_W'($signed(op_a) < $signed(op_b));
      default: alu_result = op_a + op_b;
    endcase
  end

  // Product of the operands captured when the multiply entered EX; the
  // forwarded sources may have moved on while the stall drains.
  assign product = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign is_mult      = in_valid && (alu_fn == ALU_MUL);
  assign complete_mul = (state == S_BUSY) && (cnt == '0);
  assign ex_stall     = !flush &&
                        (((state == S_IDLE) && is_mult) ||
                         ((state == S_BUSY) && (cnt != '0)));
  assign load_ex      = !flush &&
                        (((state == S_IDLE) && in_valid && !is_mult) ||
                         complete_mul);
  assign result_d     = complete_mul ? product : alu_result;

  // ---------------------------------------------------------------------------
  // Multiply FSM and EX/MEM register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      // NOTE: the operand capture registers are reset with the rest; they are
      // a handful of flops, not a RAM, so there is no cost to a known value.
      mul_a         <= '0;
      mul_b         <= '0;
      out_valid     <= 1'b0;
      ctlwb_out     <= '0;
      ctlm_out      <= '0;
      branch_target <= '0;
      aluout        <= '0;
      aluzero       <= 1'b0;
      store_data    <= '0;
      dest_reg      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      out_valid <= load_ex;

      // Data fields hold when nothing completes (bubble, stall, flush).
      if (load_ex) begin
        ctlwb_out     <= {RegWrite, MemtoReg};
        ctlm_out      <= {Branch, MemRead, MemWrite};
        branch_target <= npc + (s_extend << 2);
        aluout        <= result_d;
        aluzero       <= (result_d == '0);
        store_data    <= op_b_raw;
        dest_reg      <= RegDst ? rd : rt;
      end

      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (is_mult) begin
              mul_a <= op_a;
              mul_b <= op_b;
              cnt   <= CNT_INIT;
              state <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else           state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// -----------------------------------------------------------------------------
// tb_execute_stage_mc
//
// Self-checking bench for execute_stage_mc (DATA_W=32, REG_AW=5,
// MUL_CYCLES=4). A table of single-cycle instructions with hand-computed
// results is applied in a loop, followed by hand-written sequences for
// forwarding, bubbles, multiplies, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_execute_stage_mc;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic [31:0] npc, rdata1, rdata2, s_extend, wb_data;
  logic [4:0]  rt, rd;
  logic [1:0]  fwd_a, fwd_b;
  logic        flush;
  logic        ex_stall, out_valid, aluzero;
  logic [1:0]  ctlwb_out;
  logic [2:0]  ctlm_out;
  logic [31:0] branch_target, aluout, store_data;
  logic [4:0]  dest_reg;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage_mc #(.DATA_W(32), .REG_AW(5), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOp(ALUOp), .npc(npc), .rdata1(rdata1),
    .rdata2(rdata2), .s_extend(s_extend), .rt(rt), .rd(rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .flush(flush),
    .ex_stall(ex_stall), .out_valid(out_valid), .ctlwb_out(ctlwb_out),
    .ctlm_out(ctlm_out), .branch_target(branch_target), .aluout(aluout),
    .aluzero(aluzero), .store_data(store_data), .dest_reg(dest_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ctl packs {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
  typedef struct {
    string       name;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] exp_alu;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input string name, input logic [1:0] alu_op,
                              input logic alu_src, input logic reg_dst,
                              input logic [4:0] ctl, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm,
                              input logic [31:0] npc_v, input logic [4:0] rt_v,
                              input logic [4:0] rd_v, input logic [31:0] exp_alu,
                              input logic [31:0] exp_bt);
    vec_t v;
    v.name = name; v.alu_op = alu_op; v.alu_src = alu_src; v.reg_dst = reg_dst;
    v.ctl = ctl; v.a = a; v.b = b; v.imm = imm; v.npc = npc_v;
    v.rt = rt_v; v.rd = rd_v; v.exp_alu = exp_alu; v.exp_bt = exp_bt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_ex_stall"}, ex_stall, 0);
    check({tag, "_aluout"}, aluout, 0);
    check({tag, "_aluzero"}, aluzero, 0);
    check({tag, "_branch_target"}, branch_target, 0);
    check({tag, "_store_data"}, store_data, 0);
    check({tag, "_dest_reg"}, dest_reg, 0);
    check({tag, "_ctlwb"}, ctlwb_out, 0);
    check({tag, "_ctlm"}, ctlm_out, 0);
  endtask

  task automatic apply_vec(input vec_t v);
    in_valid = 1'b1;
    ALUOp    = v.alu_op;
    ALUSrc   = v.alu_src;
    RegDst   = v.reg_dst;
    {RegWrite, MemtoReg, Branch, MemRead, MemWrite} = v.ctl;
    rdata1   = v.a;
    rdata2   = v.b;
    s_extend = v.imm;
    npc      = v.npc;
    rt       = v.rt;
    rd       = v.rd;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
  endtask

  task automatic simple_add(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; ALUOp = 2'b00; ALUSrc = 1'b0; RegDst = 1'b1;
    {RegWrite, MemtoReg, Branch, MemRead, MemWrite} = 5'b10000;
    rdata1 = a; rdata2 = b; s_extend = 32'h0; npc = 32'h40;
    rt = 5'd1; rd = 5'd2; fwd_a = 2'b00; fwd_b = 2'b00;
  endtask

  // A operand comes from wb_data, which is changed after the first stall
  // edge, so only a captured operand gives the right product.
  task automatic run_mult(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    in_valid = 1'b1; ALUOp = 2'b10; ALUSrc = 1'b0; RegDst = 1'b1;
    {RegWrite, MemtoReg, Branch, MemRead, MemWrite} = 5'b10000;
    s_extend = 32'h18; npc = 32'h200; rt = 5'd4; rd = 5'd7;
    fwd_a = 2'b10; wb_data = a; rdata1 = 32'hBAD0_BAD0;
    fwd_b = 2'b00; rdata2 = b;
    #1;
    check({nm, "_stall_first"}, ex_stall, 1);
    cyc = 0;
    while (ex_stall === 1'b1 && cyc < 16) begin
      step();
      cyc++;
      wb_data = ~a;
      check({nm, "_bubble"}, out_valid, 0);
    end
    check({nm, "_stall_cycles"}, cyc, 3);
    step();
    check({nm, "_out_valid"}, out_valid, 1);
    check({nm, "_aluout"}, aluout, exp);
    check({nm, "_aluzero"}, aluzero, 0);
    check({nm, "_dest_reg"}, dest_reg, 7);
    check({nm, "_ctlwb"}, ctlwb_out, 2'b10);
    check({nm, "_branch"}, branch_target, 32'h260);
  endtask

  initial begin
    // Stimulus table: name, ALUOp, ALUSrc, RegDst, ctl, a, b, imm, npc, rt, rd,
    // expected aluout, expected branch_target.
    vecs[0]  = mk("sub_eq",   2'b10, 0, 1, 5'b10000, 32'd5,        32'd5,        32'h22,       32'h4,   5'd3, 5'd9, 32'd0,      32'h8C);
    vecs[1]  = mk("slt_pos",  2'b10, 0, 1, 5'b10000, 32'd3,        32'hFFFFFFFF, 32'h2A,       32'h8,   5'd3, 5'd9, 32'd0,      32'hB0);
    vecs[2]  = mk("slt_neg",  2'b10, 0, 1, 5'b10000, 32'hFFFFFFFF, 32'd3,        32'h2A,       32'hC,   5'd3, 5'd9, 32'd1,      32'hB4);
    vecs[3]  = mk("and",      2'b10, 0, 1, 5'b10000, 32'hF0F0,     32'hFF00,     32'h24,       32'h10,  5'd1, 5'd2, 32'hF000,   32'hA0);
    vecs[4]  = mk("or",       2'b10, 0, 1, 5'b10000, 32'h0F,       32'hF0,       32'h25,       32'h14,  5'd1, 5'd2, 32'hFF,     32'hA8);
    vecs[5]  = mk("add_wrap", 2'b10, 0, 1, 5'b10000, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h18,  5'd1, 5'd2, 32'd0,      32'h98);
    vecs[6]  = mk("unk_fn",   2'b10, 0, 1, 5'b10000, 32'd2,        32'd3,        32'h3F,       32'h1C,  5'd1, 5'd2, 32'd5,      32'h118);
    vecs[7]  = mk("lw",       2'b00, 1, 0, 5'b11010, 32'h100,      32'hDEAD,     32'h10,       32'h20,  5'd5, 5'd6, 32'h110,    32'h60);
    vecs[8]  = mk("beq",      2'b01, 0, 0, 5'b00100, 32'd7,        32'd7,        32'hFFFFFFFF, 32'h100, 5'd3, 5'd9, 32'd0,      32'hFC);
    vecs[9]  = mk("ori",      2'b11, 1, 0, 5'b10000, 32'h1200,     32'h77,       32'h34,       32'h24,  5'd8, 5'd1, 32'h1234,   32'hF4);
    vecs[10] = mk("sw_rt",    2'b00, 1, 0, 5'b00001, 32'h40,       32'hCAFE,     32'h18,       32'h28,  5'd3, 5'd9, 32'h58,     32'h88);

    reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
    RegDst = 0; ALUSrc = 0; MemtoReg = 0; RegWrite = 0;
    MemRead = 0; MemWrite = 0; Branch = 0; ALUOp = 2'b00;
    npc = 0; rdata1 = 0; rdata2 = 0; s_extend = 0; wb_data = 0;
    rt = 0; rd = 0; fwd_a = 2'b00; fwd_b = 2'b00;

    repeat (2) step();
    check_zero_state("reset");
    reset = 1'b1;
    step();
    check("idle_out_valid", out_valid, 0);

    // ---- Single-cycle table ----
    foreach (vecs[i]) begin
      apply_vec(vecs[i]);
      #1;
      check({vecs[i].name, "_ex_stall"}, ex_stall, 0);
      step();
      check({vecs[i].name, "_out_valid"}, out_valid, 1);
      check({vecs[i].name, "_aluout"}, aluout, vecs[i].exp_alu);
      check({vecs[i].name, "_aluzero"}, aluzero, vecs[i].exp_alu == 32'd0);
      check({vecs[i].name, "_branch"}, branch_target, vecs[i].exp_bt);
      check({vecs[i].name, "_store"}, store_data, vecs[i].b);
      check({vecs[i].name, "_dest"}, dest_reg,
            vecs[i].reg_dst ? vecs[i].rd : vecs[i].rt);
      check({vecs[i].name, "_ctlwb"}, ctlwb_out, vecs[i].ctl[4:3]);
      check({vecs[i].name, "_ctlm"}, ctlm_out, vecs[i].ctl[2:0]);
    end

    // ---- Forwarding ----
    simple_add(32'h8, 32'h8);
    step();
    check("fwd_setup_aluout", aluout, 32'h10);
    fwd_a = 2'b01; fwd_b = 2'b10; wb_data = 32'h22;
    rdata1 = 32'h1111; rdata2 = 32'h2222;
    step();
    check("fwd_aluout", aluout, 32'h32);
    check("fwd_store", store_data, 32'h22);
    fwd_a = 2'b11; fwd_b = 2'b11; rdata1 = 32'd4; rdata2 = 32'd5;
    step();
    check("fwd_11_aluout", aluout, 32'd9);

    // ---- Bubble: data fields hold ----
    in_valid = 1'b0;
    rdata1 = 32'h100; rdata2 = 32'h200;
    step();
    check("bubble_out_valid", out_valid, 0);
    check("bubble_aluout_hold", aluout, 32'd9);

    // ---- Multiplies, back to back ----
    run_mult("mul_7x6", 32'd7, 32'd6, 32'd42);
    run_mult("mul_wrap", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    in_valid = 1'b0;
    step();
    check("mul_done_out_valid", out_valid, 0);

    // ---- Flush during the second stall cycle ----
    in_valid = 1'b1; ALUOp = 2'b10; ALUSrc = 1'b0; RegDst = 1'b1;
    s_extend = 32'h18; fwd_a = 2'b00; fwd_b = 2'b00;
    rdata1 = 32'd3; rdata2 = 32'd3;
    #1;
    check("flush_stall_c1", ex_stall, 1);
    step();
    check("flush_stall_c2", ex_stall, 1);
    flush = 1'b1;
    #1;
    check("flush_stall_dropped", ex_stall, 0);
    step();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    simple_add(32'd1, 32'd2);
    #1;
    check("post_flush_stall", ex_stall, 0);
    step();
    check("post_flush_valid", out_valid, 1);
    check("post_flush_aluout", aluout, 32'd3);
    in_valid = 1'b0;
    repeat (3) begin
      step();
      check("post_flush_no_product", out_valid, 0);
    end
    check("post_flush_aluout_hold", aluout, 32'd3);

    // ---- Asynchronous reset mid-stream ----
    simple_add(32'h10, 32'h20);
    step();
    check("pre_reset_aluout", aluout, 32'h30);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_zero_state("async_reset");
    step();
    #3;
    reset = 1'b1;
    step();
    check("after_reset_out_valid", out_valid, 0);
    check("after_reset_ex_stall", ex_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
